// File: rtl/fetch_unit.sv
// Fetch responder: takes a PC, reads a 1-3 byte 6502 instruction byte by byte from
// memory and presents the assembled instruction with its sequential next PC.
module fetch_unit #(
   parameter int MEM_ADDR_SIZE = 16,
   parameter int DATA_SIZE     = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     pc_valid_i,
   input  logic [MEM_ADDR_SIZE-1:0] pc_i,
   output logic                     pc_ready_o,
   input  logic                     flush_i,
   output logic                     mem_req_o,
   output logic [MEM_ADDR_SIZE-1:0] mem_addr_o,
   input  logic                     mem_rvalid_i,
   input  logic [DATA_SIZE-1:0]     mem_rdata_i,
   output logic [DATA_SIZE-1:0]     opcode_lookup_o,
   input  logic [1:0]               op_len_i,
   output logic                     instr_valid_o,
   input  logic                     instr_ready_i,
   output logic [DATA_SIZE-1:0]     instr_opcode_o,
   output logic [DATA_SIZE-1:0]     instr_op1_o,
   output logic [DATA_SIZE-1:0]     instr_op2_o,
   output logic [1:0]               instr_len_o,
   output logic [MEM_ADDR_SIZE-1:0] instr_pc_o,
   output logic [MEM_ADDR_SIZE-1:0] next_pc_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_DONE,
      S_DRAIN
   } state_t;

   state_t                     state_q, state_d;
   logic [MEM_ADDR_SIZE-1:0]   base_q, base_d;
   logic [1:0]                 idx_q, idx_d;
   logic [1:0]                 len_q, len_d;
   logic [DATA_SIZE-1:0]       b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
   logic [1:0]                 len_eff;
   logic [1:0]                 cur_len;

   // A decoded length of 0 means a single-byte instruction.
   assign len_eff = (op_len_i == 2'd0) ? 2'd1 : op_len_i;
   assign cur_len = (idx_q == 2'd0) ? len_eff : len_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         base_q  <= '0;
         idx_q   <= '0;
         len_q   <= '0;
         b0_q    <= '0;
         b1_q    <= '0;
         b2_q    <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         b0_q    <= b0_d;
         b1_q    <= b1_d;
         b2_q    <= b2_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      base_d        = base_q;
      idx_d         = idx_q;
      len_d         = len_q;
      b0_d          = b0_q;
      b1_d          = b1_q;
      b2_d          = b2_q;
      pc_ready_o    = 1'b0;
      mem_req_o     = 1'b0;
      mem_addr_o    = '0;
      instr_valid_o = 1'b0;
      case (state_q)
         S_IDLE: begin
            pc_ready_o = 1'b1;
            if (pc_valid_i && !flush_i) begin
               base_d  = pc_i;
               idx_d   = 2'd0;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (flush_i) begin
               state_d = S_IDLE;
            end else begin
               mem_req_o  = 1'b1;
               mem_addr_o = base_q + MEM_ADDR_SIZE'(idx_q);
               state_d    = S_WAIT;
            end
         end
         S_WAIT: begin
            if (flush_i) begin
               // Read still in flight must be swallowed before accepting a new PC.
               state_d = mem_rvalid_i ? S_IDLE : S_DRAIN;
            end else if (mem_rvalid_i) begin
               case (idx_q)
                  2'd0: begin
                     b0_d  = mem_rdata_i;
                     b1_d  = '0;
                     b2_d  = '0;
                     len_d = len_eff;
                  end
                  2'd1:    b1_d = mem_rdata_i;
                  default: b2_d = mem_rdata_i;
               endcase
               if ((idx_q + 2'd1) < cur_len) begin
                  idx_d   = idx_q + 2'd1;
                  state_d = S_REQ;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            instr_valid_o = 1'b1;
            if (instr_ready_i || flush_i) state_d = S_IDLE;
         end
         S_DRAIN: begin
            if (mem_rvalid_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign opcode_lookup_o = mem_rdata_i;
   assign instr_opcode_o  = b0_q;
   assign instr_op1_o     = b1_q;
   assign instr_op2_o     = b2_q;
   assign instr_len_o     = len_q;
   assign instr_pc_o      = base_q;
   assign next_pc_o       = base_q + MEM_ADDR_SIZE'(len_q);

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Responder side of the program-counter fetch interface: accepts a PC, reads the variable-length 6502 instruction (1–3 bytes) from byte-wide memory, and presents the assembled instruction plus the sequential next PC to decode.
- Sits between the PC register and the instruction memory port.
- Instruction length comes from the combinational opcode-length decoder, looked up on the first byte.

Parameters:
- MEM_ADDR_SIZE, 16, memory address width in bits.
- DATA_SIZE, 8, memory data width in bits (one byte per access).

Ports:
- clk_i  in  1  clock; all state changes on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- pc_valid_i  in  1  fetch request valid.
- pc_i  in  MEM_ADDR_SIZE  fetch address.
- pc_ready_o  out  1  request accepted when pc_valid_i && pc_ready_o.
- flush_i  in  1  abort the current fetch (branch redirect).
- mem_req_o  out  1  one-cycle read strobe per byte.
- mem_addr_o  out  MEM_ADDR_SIZE  read address.
- mem_rvalid_i  in  1  read data valid.
- mem_rdata_i  in  DATA_SIZE  read data.
- opcode_lookup_o  out  DATA_SIZE  equals mem_rdata_i (combinational), drives the length decoder.
- op_len_i  in  2  decoded length (1..3); 0 is treated as 1.
- instr_valid_o  out  1  instruction available.
- instr_ready_i  in  1  consumer accepts when instr_valid_o && instr_ready_i.
- instr_opcode_o  out  DATA_SIZE  byte 0.
- instr_op1_o  out  DATA_SIZE  byte 1 (0 if len<2).
- instr_op2_o  out  DATA_SIZE  byte 2 (0 if len<3).
- instr_len_o  out  2  length 1..3.
- instr_pc_o  out  MEM_ADDR_SIZE  address of byte 0.
- next_pc_o  out  MEM_ADDR_SIZE  instr_pc_o + instr_len_o, mod 2^MEM_ADDR_SIZE.

Behaviour:

Reset:
- State IDLE; byte_idx=0; all instruction and memory outputs 0.
- pc_ready_o=1 (decoded from IDLE).
- Reset mid-fetch abandons the fetch. The memory port shares rst_i, so no stale rvalid follows.

FSM states:
- IDLE:
  - pc_ready_o=1.
  - On handshake: latch base=pc_i, byte_idx=0, go REQ.
  - flush_i in the same cycle wins: stay IDLE, request not accepted.
- REQ:
  - mem_req_o=1, mem_addr_o=base+byte_idx (wraps at 2^MEM_ADDR_SIZE, e.g. FFFF+1=0000); go WAIT.
- WAIT:
  - mem_req_o=0. Hold until mem_rvalid_i.
  - On rvalid: store byte in slot byte_idx.
  - If byte_idx==0, latch len=op_len_i (0→1) and clear slots 1 and 2.
  - If byte_idx+1 < len: byte_idx++, go REQ. Otherwise go DONE.
- DONE:
  - instr_valid_o=1; outputs stable while waiting.
  - On instr_ready_i: go IDLE.
  - No pc acceptance in the handshake cycle; next request is accepted at the earliest one cycle later.
- DRAIN:
  - Entered on flush_i while in WAIT with the read outstanding.
  - pc_ready_o=0; discard the next mem_rvalid_i, then go IDLE.
  - flush_i in DRAIN has no further effect.

Flush handling:
- In REQ: go IDLE without issuing mem_req_o.
- In WAIT with mem_rvalid_i in the same cycle: discard the data and go IDLE.
- In DONE: go IDLE; instr_valid_o drops the next cycle; the instruction is not consumed.

Rules:
- Only one read outstanding at any time.
- mem_rvalid_i outside WAIT/DRAIN is ignored.
- Latency with single-cycle memory: the handshake at cycle 0 gives instr_valid_o at cycle 2*len+1 (3, 5, 7).

Test Plan:
- Reset asserted mid-WAIT, then released -> pc_ready_o=1, instr_valid_o=0, mem_req_o=0, state IDLE.
- pc_i=0x8000, mem[0x8000]=0xEA, op_len_i=1 -> instr_valid_o at cycle 3; opcode=0xEA, op1=op2=0, len=1, next_pc_o=0x8001.
- pc_i=0xFFFE, bytes 4C/34/12 at FFFE/FFFF/0000, op_len_i=3 -> mem_addr_o sequence FFFE, FFFF, 0000; opcode=0x4C, op1=0x34, op2=0x12, next_pc_o=0x0001.
- Two-byte A9 05 with instr_ready_i held low 4 cycles -> instr_valid_o and all fields stable for 4 cycles; IDLE the cycle after ready; pc_ready_o reasserts.
- flush_i in WAIT of byte 1, memory rvalid 3 cycles later -> DRAIN, data discarded, no instr_valid_o, pc_ready_o=1 after rvalid.
- flush_i and pc_valid_i together in IDLE -> request not accepted, no mem_req_o; same request accepted the next cycle.
